store_unit: RTL and testbench

Memory-stage store engine for the 64-bit RISC-V multi-cycle pipeline: the write-direction counterpart of the writeback load extractor. It accepts one store (SD/SW/SH, selected by funct3), checks alignment, and places the rs2 data into the correct lanes of a 64-bit doubleword. The data memory has no byte strobes, so SW and SH use read-modify-write. The unit handshakes with data memory and holds the pipeline until the store completes.

---
 rtl/store_unit_if.sv | 21 ++
 rtl/store_unit.sv | 122 ++++++++++++
 tb/tb_store_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/store_unit_if.sv
// Data-memory port of the store engine: a read channel and a write channel
// sharing one doubleword address. No byte strobes.
interface store_unit_if;
  logic [63:0] mem_addr;
  logic        mem_rd_en;
  logic [63:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_wr_en;
  logic [63:0] mem_wdata;
  logic        mem_ack;

  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  mem_rdata, mem_rvalid, mem_ack
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output mem_rdata, mem_rvalid, mem_ack
  );
endinterface

// File: rtl/store_unit.sv
// Memory-stage store engine: accepts one SD/SW/SH, checks alignment and
// writes a full doubleword, using read-modify-write for the narrow stores.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready for a store; capture and check on st_valid
// S_READ  | fetching the old doubleword for SW/SH, merge on mem_rvalid
// S_WRITE | writing mem_wdata, wait for mem_ack
// S_RESP  | one-cycle st_done, or st_err if the check failed
module store_unit (
  input  logic        clk,
  input  logic        nrst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        st_done,
  output logic        st_err,
  store_unit_if.master mbus
);

  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [63:0] cap_addr;
  logic [2:0]  cap_funct3;
  logic [31:0] cap_wdata;
  logic        err_q;
  logic [63:0] wdata_q;
  logic        chk_ok;
  logic [63:0] merged;

  // Alignment / size check on the incoming request.
  always_comb begin
    chk_ok = 1'b0;
    case (funct3)
      F3_SD:   chk_ok = (addr[2:0] == 3'b000);
      F3_SW:   chk_ok = (addr[1:0] == 2'b00);
      F3_SH:   chk_ok = ~addr[0];
      default: chk_ok = 1'b0;
    endcase
  end

  // Splice the captured store data into the doubleword read back.
  always_comb begin
    merged = mbus.mem_rdata;
    if (cap_funct3 == F3_SW) begin
      if (cap_addr[2]) merged[63:32] = cap_wdata;
      else             merged[31:0]  = cap_wdata;
    end else begin
      case (cap_addr[2:1])
        2'd0: merged[15:0]  = cap_wdata[15:0];
        2'd1: merged[31:16] = cap_wdata[15:0];
        2'd2: merged[47:32] = cap_wdata[15:0];
        2'd3: merged[63:48] = cap_wdata[15:0];
        default: merged = mbus.mem_rdata;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (st_valid) begin
          if (!chk_ok)              state_d = S_RESP;
          else if (funct3 == F3_SD) state_d = S_WRITE;
          else                      state_d = S_READ;
        end
      end
      S_READ:  if (mbus.mem_rvalid) state_d = S_WRITE;
      S_WRITE: if (mbus.mem_ack)    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture and write-data register; SD data bypasses the merge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cap_addr   <= '0;
      cap_funct3 <= '0;
      cap_wdata  <= '0;
      err_q      <= 1'b0;
      wdata_q    <= '0;
    end else begin
      if (state_q == S_IDLE && st_valid) begin
        cap_addr   <= addr;
        cap_funct3 <= funct3;
        cap_wdata  <= wdata[31:0];
        err_q      <= ~chk_ok;
        if (chk_ok && funct3 == F3_SD) wdata_q <= wdata;
      end else if (state_q == S_READ && mbus.mem_rvalid) begin
        wdata_q <= merged;
      end
    end
  end

  // Outputs decode the state register only, so none depends on st_valid.
  always_comb begin
    st_ready       = (state_q == S_IDLE);
    st_done        = (state_q == S_RESP) && !err_q;
    st_err         = (state_q == S_RESP) &&  err_q;
    mbus.mem_rd_en = (state_q == S_READ);
    mbus.mem_wr_en = (state_q == S_WRITE);
    mbus.mem_addr  = {cap_addr[63:3], 3'b000};
    mbus.mem_wdata = wdata_q;
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with a small doubleword memory, a reference
// merge model and a per-cycle bus monitor.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [2:0]  funct3 = '0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        st_done;
  logic        st_err;

  store_unit_if mif ();

  store_unit dut (
    .clk(clk), .nrst(nrst), .st_valid(st_valid), .st_ready(st_ready),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .st_done(st_done), .st_err(st_err), .mbus(mif.master)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [63:0] mem [0:7];
  int          rd_wait = 0, ack_wait = 0;
  bit          stray = 1'b0;
  logic [63:0] exp_addr = '0, exp_wdata = '0;
  int          rd_cyc = 0, wr_cyc = 0, done_cnt = 0, err_cnt = 0, commits = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: byte-offset arithmetic on the old doubleword.
  function automatic logic [63:0] model_merge(input logic [2:0] f3, input logic [63:0] a,
                                              input logic [63:0] w, input logic [63:0] old);
    int nbits, sh;
    logic [63:0] mask;
    if (f3 == 3'b011) return w;
    nbits = 8 * (1 << f3);
    sh    = int'(a % 8) * 8;
    mask  = ((64'd1 << nbits) - 64'd1) << sh;
    return (old & ~mask) | ((w << sh) & mask);
  endfunction

  function automatic bit model_err(input logic [2:0] f3, input logic [63:0] a);
    if (f3 != 3'b001 && f3 != 3'b010 && f3 != 3'b011) return 1'b1;
    return (a % (64'd1 << f3)) != 0;
  endfunction

  // Memory responder: rvalid/ack after the configured number of wait cycles.
  int rcnt = 0, wcnt = 0;
  initial begin
    mif.mem_rvalid = 1'b0;
    mif.mem_ack    = 1'b0;
    mif.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        mif.mem_rvalid = 1'b0; mif.mem_ack = 1'b0; rcnt = 0; wcnt = 0;
      end else begin
        if (mif.mem_rd_en) begin
          if (rcnt == rd_wait) begin
            mif.mem_rvalid = 1'b1;
            mif.mem_rdata  = mem[mif.mem_addr[5:3]];
          end else begin
            mif.mem_rvalid = 1'b0;
            mif.mem_rdata  = 64'h5A5A_5A5A_5A5A_5A5A;
          end
          rcnt++;
        end else begin
          rcnt = 0;
          mif.mem_rvalid = stray && !mif.mem_wr_en;
          mif.mem_rdata  = 64'h5A5A_5A5A_5A5A_5A5A;
        end
        if (mif.mem_wr_en) begin
          mif.mem_ack = (wcnt == ack_wait);
          wcnt++;
        end else begin
          wcnt = 0;
          mif.mem_ack = stray && !mif.mem_rd_en;
        end
      end
    end
  end

  // Memory commit on an accepted write.
  initial forever begin
    @(posedge clk);
    if (nrst && mif.mem_wr_en && mif.mem_ack) begin
      mem[mif.mem_addr[5:3]] = mif.mem_wdata;
      commits++;
    end
  end

  // Per-cycle bus monitor.
  initial forever begin
    @(negedge clk);
    if (nrst) begin
      if (mif.mem_rd_en || mif.mem_wr_en) chk("rd_wr_exclusive", {63'd0, mif.mem_rd_en & mif.mem_wr_en}, 64'd0);
      if (mif.mem_rd_en) begin
        rd_cyc++;
        chk("rd_addr", mif.mem_addr, exp_addr);
      end
      if (mif.mem_wr_en) begin
        wr_cyc++;
        chk("wr_addr", mif.mem_addr, exp_addr);
        chk("wr_data", mif.mem_wdata, exp_wdata);
      end
      if (st_done) done_cnt++;
      if (st_err)  err_cnt++;
    end
  end

  task automatic run_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] w,
                           input logic [63:0] pre, input int rw, input int aw, input bit poke);
    int idx, lat, exp_rd, exp_wr, k;
    bit e, ready_bad, seen;
    logic [63:0] exp_word;
    idx = int'(a[5:3]);
    e = model_err(f3, a);
    exp_word = e ? pre : model_merge(f3, a, w, pre);
    lat    = e ? 1 : (f3 == 3'b011 ? 2 + aw : 3 + rw + aw);
    exp_rd = (e || f3 == 3'b011) ? 0 : rw + 1;
    exp_wr = e ? 0 : aw + 1;
    @(negedge clk); #1;
    mem[idx] = pre;
    rd_wait = rw; ack_wait = aw;
    exp_addr = {a[63:3], 3'b000};
    exp_wdata = exp_word;
    rd_cyc = 0; wr_cyc = 0; done_cnt = 0; err_cnt = 0;
    chk("ready_before", {63'd0, st_ready}, 64'd1);
    st_valid = 1'b1; funct3 = f3; addr = a; wdata = w;
    k = 0; ready_bad = 0; seen = 0;
    while (!seen && k < lat + 20) begin
      @(negedge clk); #1;
      k++;
      if (poke) begin
        funct3 = 3'b011; addr = 64'h30; wdata = 64'hDEAD_0000_DEAD_0000;
      end else begin
        st_valid = 1'b0;
      end
      if (st_ready) ready_bad = 1;
      seen = st_done || st_err;
    end
    st_valid = 1'b0;
    if (!seen) begin
      chk("response_timeout", 64'd0, 64'd1);
      nrst = 1'b0; #2 nrst = 1'b1;
      return;
    end
    chk("latency", k, lat);
    chk("ready_low_busy", {63'd0, ready_bad}, 64'd0);
    chk("err_flag", {63'd0, st_err}, {63'd0, e});
    chk("done_flag", {63'd0, st_done}, {63'd0, !e});
    chk("rd_cycles", rd_cyc, exp_rd);
    chk("wr_cycles", wr_cyc, exp_wr);
    @(negedge clk); #1;
    chk("ready_after", {63'd0, st_ready}, 64'd1);
    chk("single_pulse", done_cnt + err_cnt, 1);
    chk("mem_word", mem[idx], exp_word);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 64'h0;
    #1;
    chk("rst_ready", {63'd0, st_ready}, 64'd1);
    chk("rst_done_err", {62'd0, st_done, st_err}, 64'd0);
    chk("rst_rd_wr", {62'd0, mif.mem_rd_en, mif.mem_wr_en}, 64'd0);
    chk("rst_addr", mif.mem_addr, 64'd0);
    chk("rst_wdata", mif.mem_wdata, 64'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    // Pin the reference model to hand-computed words.
    chk("model_sw", model_merge(3'b010, 64'h0C, 64'hFFFFFFFF_DEADBEEF, 64'hAAAAAAAA_BBBBBBBB), 64'hDEADBEEF_BBBBBBBB);
    chk("model_sh1", model_merge(3'b001, 64'h22, 64'hCAFE, 64'h0123456789ABCDEF), 64'h01234567CAFECDEF);

    run_store(3'b011, 64'h10, 64'h1122334455667788, 64'h0, 0, 0, 0);
    chk("lit_sd", mem[2], 64'h1122334455667788);
    run_store(3'b010, 64'h0C, 64'hFFFFFFFF_DEADBEEF, 64'hAAAAAAAA_BBBBBBBB, 0, 0, 0);
    chk("lit_sw", mem[1], 64'hDEADBEEF_BBBBBBBB);
    run_store(3'b001, 64'h22, 64'hCAFE, 64'h0123456789ABCDEF, 0, 0, 0);
    chk("lit_sh_l1", mem[4], 64'h01234567CAFECDEF);
    run_store(3'b001, 64'h20, 64'hCAFE, 64'h0123456789ABCDEF, 0, 0, 0);
    chk("lit_sh_l0", mem[4], 64'h0123456789ABCAFE);
    run_store(3'b001, 64'h24, 64'hCAFE, 64'h0123456789ABCDEF, 0, 0, 0);
    chk("lit_sh_l2", mem[4], 64'h0123CAFE89ABCDEF);
    run_store(3'b001, 64'h26, 64'hCAFE, 64'h0123456789ABCDEF, 0, 0, 0);
    chk("lit_sh_l3", mem[4], 64'hCAFE456789ABCDEF);

    // Rejected stores, with stray rvalid/ack driven while idle.
    stray = 1'b1;
    run_store(3'b010, 64'h06, 64'h1234, 64'h7777_7777_7777_7777, 0, 0, 0);
    run_store(3'b000, 64'h00, 64'h1234, 64'h6666_6666_6666_6666, 0, 0, 0);
    run_store(3'b011, 64'h04, 64'h1234, 64'h5555_0000_5555_0000, 0, 0, 0);
    run_store(3'b001, 64'h01, 64'h1234, 64'h4444_4444_4444_4444, 0, 0, 0);
    chk("lit_err_mem", mem[0], 64'h4444_4444_4444_4444);
    stray = 1'b0;

    // Wait states with a second request held on st_valid while busy.
    run_store(3'b010, 64'h1C, 64'h0000_0000_0BAD_F00D, 64'h1111_2222_3333_4444, 3, 2, 1);
    chk("lit_sw_wait", mem[3], 64'h0BADF00D_33334444);
    chk("lit_sw_wait_rd", rd_cyc, 4);
    chk("lit_sw_wait_wr", wr_cyc, 3);

    // Reset during the WRITE of an SD.
    mem[2] = 64'hABAB_ABAB_ABAB_ABAB;
    rd_wait = 0; ack_wait = 20;
    exp_addr = 64'h10; exp_wdata = 64'h0F0F_0F0F_0F0F_0F0F;
    @(negedge clk); #1;
    st_valid = 1'b1; funct3 = 3'b011; addr = 64'h10; wdata = 64'h0F0F_0F0F_0F0F_0F0F;
    @(negedge clk); #1;
    st_valid = 1'b0;
    chk("rst_mid_wr_before", {63'd0, mif.mem_wr_en}, 64'd1);
    @(negedge clk); #2;
    nrst = 1'b0;
    #1;
    chk("rst_mid_wr_en", {63'd0, mif.mem_wr_en}, 64'd0);
    chk("rst_mid_ready", {63'd0, st_ready}, 64'd1);
    chk("rst_mid_addr", mif.mem_addr, 64'd0);
    chk("rst_mid_wdata", mif.mem_wdata, 64'd0);
    done_cnt = 0; wr_cyc = 0; commits = 0;
    @(negedge clk); #1;
    nrst = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("rst_no_done", done_cnt, 0);
    chk("rst_no_write", wr_cyc + commits, 0);
    chk("rst_mem_kept", mem[2], 64'hABAB_ABAB_ABAB_ABAB);
    run_store(3'b011, 64'h10, 64'h8877665544332211, 64'hABAB_ABAB_ABAB_ABAB, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
